// File: rtl/niossys_mycpu_cpu_debug_monitor.sv
`default_nettype none
// ============================================================================
// Module   : niossys_mycpu_cpu_debug_monitor
// Brief    : Sysclk-domain debug monitor. Executes single-word reads/writes
//            for decoded JTAG debug commands over an Avalon-MM master port
//            and returns MonDReg / monitor_ready / monitor_error.
// Options  : DEBUG_MONITOR_TIMEOUT_EN - abort stalled transfers after TIMEOUT
//            waitrequest cycles (MonDReg = 32'hDEADBEEF, error flagged).
// Revision : 1.0 - initial release
// ============================================================================
module niossys_mycpu_cpu_debug_monitor #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W+1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  input  logic [31:0]       m_readdata,
  input  logic              m_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  logic accept_a;
  logic accept_b;
  logic addr_only;
  logic start_xfer;
  logic xfer_ok;
  logic timeout_hit;
  logic busy_strobe;
  logic wait_hit;
  logic in_xfer;

  // Jdo bits that carry no meaning for this engine
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign in_xfer     = (state == S_READ) || (state == S_WRITE);
  assign m_address   = {addr, 2'b00};
  assign m_writedata = wdata;

`ifdef DEBUG_MONITOR_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt;

  // Count stalled cycles of the current transfer; cleared whenever no transfer is active
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!in_xfer) begin
      wait_cnt <= '0;
    end else if (m_waitrequest) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // The TIMEOUT-th consecutive stalled cycle aborts the transfer
  assign wait_hit = in_xfer && m_waitrequest && (wait_cnt == WAIT_LAST);
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
  assign wait_hit       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and command decode (priority a > b > no_action_a)
  always_comb begin
    state_next  = state;
    accept_a    = 1'b0;
    accept_b    = 1'b0;
    start_xfer  = 1'b0;
    xfer_ok     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (take_action_ocimem_a) begin
          accept_a = 1'b1;
          if (jdo[34]) begin
            start_xfer = 1'b1;
            state_next = S_READ;
          end
        end else if (take_action_ocimem_b) begin
          accept_b   = 1'b1;
          start_xfer = 1'b1;
          state_next = S_WRITE;
        end else if (take_no_action_ocimem_a) begin
          start_xfer = 1'b1;
          state_next = S_READ;
        end
      end
      S_READ, S_WRITE: begin
        if (!m_waitrequest) begin
          xfer_ok    = 1'b1;
          state_next = S_DONE;
        end else if (wait_hit) begin
          timeout_hit = 1'b1;
          state_next  = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign addr_only   = accept_a && !jdo[34];
  assign busy_strobe = (state != S_IDLE) &&
                       (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a);

  // Address, write data and registered bus strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr    <= '0;
      wdata   <= '0;
      m_read  <= 1'b0;
      m_write <= 1'b0;
    end else begin
      if (accept_a) begin
        addr <= jdo[17+ADDR_W-1:17];
      end else if (state == S_DONE) begin
        addr <= addr + 1'b1;
      end
      if (accept_b) begin
        wdata <= jdo[34:3];
      end
      m_read  <= (state_next == S_READ);
      m_write <= (state_next == S_WRITE);
    end
  end

  // Status returned to the TCK side: data, ready and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (xfer_ok) begin
        MonDReg <= (state == S_READ) ? m_readdata : wdata;
      end else if (timeout_hit) begin
        MonDReg <= TIMEOUT_PATTERN;
      end

      if (addr_only || (state == S_DONE)) begin
        monitor_ready <= 1'b1;
      end else if (start_xfer) begin
        monitor_ready <= 1'b0;
      end

      if (busy_strobe || timeout_hit) begin
        monitor_error <= 1'b1;
      end else if (accept_a && jdo[35]) begin
        monitor_error <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_niossys_mycpu_cpu_debug_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_niossys_mycpu_cpu_debug_monitor
// Brief    : Scoreboard bench for the debug monitor with a simple Avalon slave
//            model (programmable wait states, fixed read data).
// Options  : DEBUG_MONITOR_TIMEOUT_EN enables the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_niossys_mycpu_cpu_debug_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0;
  logic        tna_a = 1'b0;
  logic        ta_b = 1'b0;
  logic [11:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int n_total = 0;
  int n_bad   = 0;

  // Slave model controls and observations
  int          wait_n    = 0;
  logic        hold_wait = 1'b0;
  logic [31:0] rd_value  = '0;
  int          bus_cnt   = 0;
  int          rd_acc    = 0;
  int          wr_acc    = 0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  logic [11:0] acc_addr  = '0;
  logic [31:0] last_wdata = '0;

  typedef struct {
    logic [31:0] dreg;
    logic [11:0] addr;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  niossys_mycpu_cpu_debug_monitor #(
    .ADDR_W (10),
    .TIMEOUT(8)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (ta_a),
    .take_no_action_ocimem_a(tna_a),
    .take_action_ocimem_b   (ta_b),
    .m_address              (m_address),
    .m_read                 (m_read),
    .m_write                (m_write),
    .m_writedata            (m_writedata),
    .m_readdata             (m_readdata),
    .m_waitrequest          (m_waitrequest),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  always #5 clk = ~clk;

  assign m_waitrequest = hold_wait || ((m_read || m_write) && (bus_cnt < wait_n));
  assign m_readdata    = rd_value;

  // Slave: stall wait_n cycles per request, record accepted transfers
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_cnt <= 0;
    end else if (m_read || m_write) begin
      if (m_read)  rd_cycles <= rd_cycles + 1;
      if (m_write) wr_cycles <= wr_cycles + 1;
      if (m_waitrequest) begin
        bus_cnt <= bus_cnt + 1;
      end else begin
        bus_cnt  <= 0;
        acc_addr <= m_address;
        if (m_read) rd_acc <= rd_acc + 1;
        else begin
          wr_acc     <= wr_acc + 1;
          last_wdata <= m_writedata;
        end
      end
    end else begin
      bus_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // kind: 0 = take_action_a, 1 = take_no_action_a, 2 = take_action_b
  task automatic do_cmd(input int kind, input logic [9:0] a, input logic rd, input logic clr,
                        input logic [31:0] data, input logic [31:0] exp_dreg,
                        input logic [11:0] exp_addr, input int exp_lat, input int collide);
    exp_t e;
    int   lat;
    e.dreg = exp_dreg;
    e.addr = exp_addr;
    e.lat  = exp_lat;
    @(negedge clk);
    jdo = '0;
    if (kind == 2) begin
      jdo[34:3] = data;
      ta_b = 1'b1;
    end else if (kind == 1) begin
      tna_a = 1'b1;
    end else begin
      jdo[26:17] = a;
      jdo[34]    = rd;
      jdo[35]    = clr;
      ta_a = 1'b1;
    end
    exp_q.push_back(e);
    @(negedge clk);
    ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    lat = 1;
    while (!monitor_ready && lat < 200) begin
      if (collide != 0 && lat == collide) tna_a = 1'b1;
      @(negedge clk);
      tna_a = 1'b0;
      lat++;
    end
    check("ready_seen", 64'(monitor_ready), 64'(1'b1));
    if (exp_q.size() == 0) begin
      check("sb_nonempty", 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check("mondreg", 64'(MonDReg), 64'(e.dreg));
      check("address", 64'(m_address), 64'(e.addr));
      check("latency", 64'(lat), 64'(e.lat));
    end
  endtask

  initial begin
    int r0, w0, rc0, wc0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_mondreg", 64'(MonDReg), 64'(0));
    check("rst_ready",   64'(monitor_ready), 64'(0));
    check("rst_error",   64'(monitor_error), 64'(0));
    check("rst_strobes", 64'({m_read, m_write}), 64'(0));
    check("rst_addr",    64'(m_address), 64'(0));
    check("rst_wdata",   64'(m_writedata), 64'(0));
    reset = 1'b0;

    // Address-only load
    r0 = rd_acc; w0 = wr_acc;
    do_cmd(0, 10'h010, 1'b0, 1'b0, 32'h0, 32'h0, 12'h040, 1, 0);
    check("ld_no_strobe", 64'({m_read, m_write}), 64'(0));
    @(negedge clk);
    check("ld_no_access", 64'(rd_acc - r0 + wr_acc - w0), 64'(0));

    // Zero-wait read at the top word, address wraps
    rd_value = 32'h12345678; wait_n = 0;
    do_cmd(0, 10'h3FF, 1'b1, 1'b0, 32'h0, 32'h12345678, 12'h000, 3, 0);
    check("rd0_acc_addr", 64'(acc_addr), 64'(12'hFFC));

    // Next-word read with 3 wait states
    rd_value = 32'hA5A50001; wait_n = 3;
    do_cmd(1, 10'h0, 1'b0, 1'b0, 32'h0, 32'hA5A50001, 12'h004, 6, 0);
    check("rd3_acc_addr", 64'(acc_addr), 64'(12'h000));

    // Write with 4 wait states
    wait_n = 4; wc0 = wr_cycles;
    do_cmd(2, 10'h0, 1'b0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 12'h008, 7, 0);
    check("wr_cycles",   64'(wr_cycles - wc0), 64'(5));
    check("wr_data",     64'(last_wdata), 64'(32'hCAFEF00D));
    check("wr_acc_addr", 64'(acc_addr), 64'(12'h004));
    check("wr_no_error", 64'(monitor_error), 64'(0));

    // Strobe during a stalled read is dropped and flags an error
    rd_value = 32'h13572468; wait_n = 5; r0 = rd_acc; rc0 = rd_cycles;
    do_cmd(1, 10'h0, 1'b0, 1'b0, 32'h0, 32'h13572468, 12'h00C, 8, 2);
    @(negedge clk); @(negedge clk);
    check("coll_single_rd", 64'(rd_acc - r0), 64'(1));
    check("coll_rd_cycles", 64'(rd_cycles - rc0), 64'(6));
    check("coll_error",     64'(monitor_error), 64'(1));

    // Address load with error clear
    do_cmd(0, 10'h020, 1'b0, 1'b1, 32'h0, 32'h13572468, 12'h080, 1, 0);
    check("clr_error", 64'(monitor_error), 64'(0));

`ifdef DEBUG_MONITOR_TIMEOUT_EN
    // Slave never releases: transfer aborts after 8 stalled cycles
    hold_wait = 1'b1; rc0 = rd_cycles; r0 = rd_acc;
    do_cmd(0, 10'h005, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 12'h018, 10, 0);
    check("to_rd_cycles", 64'(rd_cycles - rc0), 64'(8));
    check("to_no_accept", 64'(rd_acc - r0), 64'(0));
    check("to_error",     64'(monitor_error), 64'(1));
    hold_wait = 1'b0;
`endif

    // Asynchronous reset in the middle of a stalled write
    wait_n = 10; w0 = wr_acc;
    @(negedge clk);
    jdo = '0; jdo[34:3] = 32'h11223344; ta_b = 1'b1;
    @(negedge clk);
    ta_b = 1'b0;
    check("arst_wr_active", 64'(m_write), 64'(1));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_strobes", 64'({m_read, m_write}), 64'(0));
    check("arst_mondreg", 64'(MonDReg), 64'(0));
    check("arst_flags",   64'({monitor_ready, monitor_error}), 64'(0));
    check("arst_addr",    64'(m_address), 64'(0));
    check("arst_wdata",   64'(m_writedata), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    check("arst_no_wr", 64'(wr_acc - w0), 64'(0));

    // Normal read after reset release
    wait_n = 0; rd_value = 32'h0BADF00D;
    do_cmd(1, 10'h0, 1'b0, 1'b0, 32'h0, 32'h0BADF00D, 12'h004, 3, 0);
    check("post_rst_acc_addr", 64'(acc_addr), 64'(12'h000));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
